psram_responder: RTL

- Synthesizable SPI-mode PSRAM device model: the target-side counterpart to the team's PSRAM command initiator.
- Sits on-chip, or in the bench, wired to the initiator's ce_n, clk and sio[0] pins, and answers on sio[1].
- Decodes Reset Enable (0x66), Reset (0x99), Write (0x02), Read (0x03) and Read ID (0x9F) against a small internal byte array.
- Used for loopback bring-up of the initiator without the external device.

---
 rtl/psram_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/psram_responder.sv
// psram_responder: SPI-mode PSRAM target model that decodes reset, write, read and read-ID frames
// against a small on-chip byte array, for loopback bring-up of the command initiator.
module psram_responder #(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] MFID   = 8'h0D,
  parameter logic [7:0] KGD    = 8'h5D
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       ce_n,
  input  logic       spi_clk,
  input  logic       si,
  output logic       so,
  output logic       so_oe,
  output logic       rst_pulse,
  output logic       cmd_strobe,
  output logic [7:0] last_cmd,
  output logic       err_cmd
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] WDATA  = 3'd3;
  localparam logic [2:0] RDATA  = 3'd4;
  localparam logic [2:0] IGNORE = 3'd5;
  // bits [1:0] synchronise, bit [2] holds the previous synced value for edge detection
  logic [2:0]        ce_sq, sck_sq;
  logic [1:0]        si_sq;
  logic [2:0]        state_q;
  logic [4:0]        bcnt_q;
  logic [2:0]        rbit_q;
  logic [7:0]        shift_q, out_q, rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        id_idx_q;
  logic              rd_id_q, cmd_done_q, extra_q, armed_q;
  logic [7:0]        mem_q [2**ADDR_W];
  logic              ce_fall, ce_rise, sck_rise, sck_fall, si_s, we;
  logic [7:0]        in_byte, id_byte, src_byte, cur_byte;
  assign ce_fall  = ce_sq[2] & ~ce_sq[1];
  assign ce_rise  = ~ce_sq[2] & ce_sq[1];
  assign sck_rise = ~sck_sq[2] & sck_sq[1];
  assign sck_fall = sck_sq[2] & ~sck_sq[1];
  assign si_s     = si_sq[1];
  assign in_byte  = {shift_q[6:0], si_s};
  assign id_byte  = id_idx_q == 2'd0 ? MFID : id_idx_q == 2'd1 ? KGD : 8'h00;
  assign src_byte = rd_id_q ? id_byte : rdata_q;
  // the first bit of every byte comes straight from the source so no load cycle is needed
  assign cur_byte = rbit_q == 3'd0 ? src_byte : out_q;
  assign we       = !sys_reset && !ce_rise && state_q == WDATA && sck_rise && bcnt_q == 5'd7;
  always_ff @(posedge sys_clk) begin
    if (we) mem_q[addr_q] <= in_byte;
    rdata_q <= mem_q[addr_q];
  end
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      ce_sq      <= '0;
      sck_sq     <= '0;
      si_sq      <= '0;
      state_q    <= IDLE;
      bcnt_q     <= '0;
      rbit_q     <= '0;
      shift_q    <= '0;
      out_q      <= '0;
      addr_q     <= '0;
      id_idx_q   <= '0;
      rd_id_q    <= 1'b0;
      cmd_done_q <= 1'b0;
      extra_q    <= 1'b0;
      armed_q    <= 1'b0;
      so         <= 1'b0;
      so_oe      <= 1'b0;
      rst_pulse  <= 1'b0;
      cmd_strobe <= 1'b0;
      last_cmd   <= '0;
      err_cmd    <= 1'b0;
    end else begin
      ce_sq      <= {ce_sq[1:0], ce_n};
      sck_sq     <= {sck_sq[1:0], spi_clk};
      si_sq      <= {si_sq[0], si};
      cmd_strobe <= 1'b0;
      rst_pulse  <= 1'b0;
      if (ce_rise) begin
        state_q    <= IDLE;
        so_oe      <= 1'b0;
        so         <= 1'b0;
        bcnt_q     <= '0;
        rbit_q     <= '0;
        id_idx_q   <= '0;
        cmd_done_q <= 1'b0;
        extra_q    <= 1'b0;
        if (cmd_done_q) begin
          armed_q   <= last_cmd == 8'h66 && !extra_q;
          rst_pulse <= last_cmd == 8'h99 && !extra_q && armed_q;
        end
      end else begin
        case (state_q)
          IDLE: if (ce_fall) begin
            state_q <= CMD;
            bcnt_q  <= '0;
          end
          CMD: if (sck_rise) begin
            shift_q <= in_byte;
            bcnt_q  <= bcnt_q == 5'd7 ? 5'd0 : bcnt_q + 5'd1;
            if (bcnt_q == 5'd7) begin
              cmd_strobe <= 1'b1;
              last_cmd   <= in_byte;
              cmd_done_q <= 1'b1;
              state_q    <= in_byte == 8'h02 || in_byte == 8'h03 || in_byte == 8'h9F ? ADDR : IGNORE;
              if (!(in_byte inside {8'h02, 8'h03, 8'h9F, 8'h66, 8'h99})) err_cmd <= 1'b1;
            end
          end
          ADDR: if (sck_rise) begin
            addr_q <= {addr_q[ADDR_W-2:0], si_s};
            bcnt_q <= bcnt_q == 5'd23 ? 5'd0 : bcnt_q + 5'd1;
            if (bcnt_q == 5'd23) begin
              state_q  <= last_cmd == 8'h02 ? WDATA : RDATA;
              rd_id_q  <= last_cmd == 8'h9F;
              rbit_q   <= '0;
              id_idx_q <= '0;
            end
          end
          WDATA: if (sck_rise) begin
            shift_q <= in_byte;
            bcnt_q  <= bcnt_q == 5'd7 ? 5'd0 : bcnt_q + 5'd1;
            if (bcnt_q == 5'd7) addr_q <= addr_q + 1'b1;
          end
          RDATA: if (sck_fall) begin
            so_oe  <= 1'b1;
            so     <= cur_byte[7];
            out_q  <= {cur_byte[6:0], 1'b0};
            rbit_q <= rbit_q + 3'd1;
            if (rbit_q == 3'd7) begin
              addr_q   <= addr_q + 1'b1;
              id_idx_q <= id_idx_q == 2'd2 ? 2'd2 : id_idx_q + 2'd1;
            end
          end
          IGNORE: if (sck_rise) extra_q <= 1'b1;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
